reg_file_master: RTL
====================

Name: reg_file_master

Overview:
- Serial initiator for the serial register-file slave. It converts parallel read/write requests into the strobe + serial address + serial data frame on RD_EN/WR_EN/DIN, and collects read data from DOUT.
- Sits between the control-plane logic (parallel request/response) and one register-file slave. Shares CLK/RSTN with the slave.

Parameters:
- ADDR_WIDTH, 8, serial address bits per frame; must equal the slave's address width (slave frame counter supports 8 only).
- DATA_WIDTH, 8, serial data bits per frame; must equal the slave's data width (8 only).
- GAP_CYCLES, 1, idle cycles forced after each frame before the next request is accepted; legal range 1..15.

Ports:
- CLK  in  1  clock, all logic on rising edge
- RSTN  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready at a rising edge
- req_wr  in  1  1 = write, 0 = read; sampled at acceptance
- req_addr  in  ADDR_WIDTH  target register address; sampled at acceptance
- req_wdata  in  DATA_WIDTH  write data; sampled at acceptance
- rsp_valid  out  1  one-cycle pulse, transaction complete
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid; 0 for plain writes
- rsp_err  out  1  readback mismatch, valid with rsp_valid (see Optional Feature)
- RD_EN  out  1  read strobe to slave
- WR_EN  out  1  write strobe to slave
- DIN  out  1  serial address/data to slave
- DOUT  in  1  serial read data from slave

Behaviour:
- Interface: one clock CLK; RSTN is synchronous and active-low. While RSTN=0 at a rising edge: FSM -> IDLE, RD_EN=WR_EN=DIN=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, all counters and shift regs 0.
- RD_EN, WR_EN, DIN, rsp_* are registered. req_ready is decoded from the state register: 1 only in IDLE, so it is 1 in the first cycle after reset.
- FSM states: IDLE, STROBE, ADDR, DATA, GAP.
- IDLE: on accept, latch req_wr/addr/wdata, then go to STROBE. req_* inputs are ignored in all other states.
- STROBE, 1 cycle: WR_EN=1 for a write, RD_EN=1 for a read, DIN=0. The two strobes are never high together.
- ADDR, ADDR_WIDTH cycles: DIN = addr MSB first, one bit per cycle.
- DATA, DATA_WIDTH cycles:
  - Write: DIN = wdata MSB first.
  - Read: DIN=0; DOUT is sampled at the end of each DATA cycle and shifted into rdata MSB first (first sample = bit 7).
- GAP, GAP_CYCLES cycles: all slave-side outputs 0. rsp_valid=1 in the first GAP cycle only. Then go to IDLE.
- Timing, with acceptance edge at the end of cycle A:
  - STROBE at A+1, ADDR at A+2..A+9, DATA at A+10..A+17.
  - rsp_valid at A+18.
  - Earliest next acceptance at A+18+GAP_CYCLES.
  - Strobe-to-strobe spacing is at least 18+GAP_CYCLES. With the minimum of 1 this always satisfies the slave's frame counter, which is idle again 17 cycles after a strobe.
- Reset mid-frame (any state): frame aborted, no rsp_valid, outputs to reset values. The slave shares RSTN, so both ends resync.
- req_valid held high continuously: one acceptance per frame, no request dropped or duplicated.
- Slave address map (informative, slave defaults): 0x34, 0x78, 0xA1, 0x06 are R/W and reset to 0x00. 0x55 is read-only and reads 0x33. Unmapped addresses read 0x00.

Optional Feature:
- Macro: REG_FILE_MASTER_VERIFY_EN.
- Defined:
  - After a write frame's GAP, the block issues an internal read frame to the same address (STROBE/ADDR/DATA/GAP again, req_ready stays 0).
  - rsp_valid fires only after the readback, at A+36+GAP_CYCLES.
  - rsp_rdata = readback value; rsp_err = (readback != written data).
  - Reads are unchanged.
- Undefined: no readback; rsp_err tied 0; write rsp_valid at A+18 with rsp_rdata=0.

Test Plan:
- Reset, then read 0x55 -> RD_EN pulse 1 cycle after acceptance; DIN = 0,1,0,1,0,1,0,1; rsp_valid 18 cycles after acceptance with rsp_rdata=0x33, rsp_err=0.
- Write 0x34 data 0xA5, then read 0x34 -> write DIN data bits 1,0,1,0,0,1,0,1; the read returns rsp_rdata=0xA5.
- Read unmapped 0x00 -> rsp_rdata=0x00. Write 0x78 data 0x5A, read 0xA1 -> 0x00 (no aliasing).
- req_valid held high for 3 requests with GAP_CYCLES=1 -> strobes exactly 19 cycles apart, 3 rsp_valid pulses, req_ready=0 between acceptances.
- Assert RSTN=0 for 1 cycle during the ADDR phase of a write to 0x06 -> no rsp_valid; all outputs 0; next read of 0x06 returns 0x00.
- With REG_FILE_MASTER_VERIFY_EN: write 0x55 data 0x00 -> automatic readback frame; rsp_rdata=0x33, rsp_err=1. Write 0x06 data 0xC3 -> rsp_rdata=0xC3, rsp_err=0.

Source files
------------

// File: rtl/reg_file_master.sv
// ============================================================================
// Module   : reg_file_master
// Purpose  : Serial initiator that turns parallel register requests into
//            strobe + serial address + serial data frames for a register-file
//            slave, and collects read data from DOUT.
// Option   : REG_FILE_MASTER_VERIFY_EN adds an automatic readback after writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  RD_EN,
  output logic                  WR_EN,
  output logic                  DIN,
  input  logic                  DOUT
);

  localparam logic [4:0] ADDR_LAST = 5'(ADDR_WIDTH - 1);
  localparam logic [4:0] DATA_LAST = 5'(DATA_WIDTH - 1);
  localparam logic [4:0] GAP_LAST  = 5'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STROBE = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t                state;
  logic                  is_wr;
  logic [4:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0] wdata_sr;
  logic [DATA_WIDTH-2:0] rdata_sr;
  logic [DATA_WIDTH-1:0] rdata_next;
  logic [4:0]            gap_last;

  assign req_ready  = (state == S_IDLE);
  assign rdata_next = {rdata_sr, DOUT};

`ifdef REG_FILE_MASTER_VERIFY_EN
  logic                  vpend;
  logic                  readback;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  assign rsp_err = err_q;
  // One extra gap cycle before the readback keeps its response at A+36+GAP.
  assign gap_last = vpend ? GAP_LAST + 5'd1 : GAP_LAST;
`else
  assign rsp_err  = 1'b0;
  assign gap_last = GAP_LAST;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state     <= S_IDLE;
      is_wr     <= 1'b0;
      cnt       <= '0;
      addr_sr   <= '0;
      wdata_sr  <= '0;
      rdata_sr  <= '0;
      RD_EN     <= 1'b0;
      WR_EN     <= 1'b0;
      DIN       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef REG_FILE_MASTER_VERIFY_EN
      vpend     <= 1'b0;
      readback  <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            state    <= S_STROBE;
            is_wr    <= req_wr;
            addr_sr  <= req_addr;
            wdata_sr <= req_wdata;
            WR_EN    <= req_wr;
            RD_EN    <= !req_wr;
            DIN      <= 1'b0;
            cnt      <= '0;
`ifdef REG_FILE_MASTER_VERIFY_EN
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            readback <= 1'b0;
`endif
          end
        end
        S_STROBE: begin
          state   <= S_ADDR;
          RD_EN   <= 1'b0;
          WR_EN   <= 1'b0;
          DIN     <= addr_sr[ADDR_WIDTH-1];
          addr_sr <= {addr_sr[ADDR_WIDTH-2:0], 1'b0};
          cnt     <= '0;
        end
        S_ADDR: begin
          if (cnt == ADDR_LAST) begin
            state    <= S_DATA;
            cnt      <= '0;
            DIN      <= is_wr & wdata_sr[DATA_WIDTH-1];
            wdata_sr <= {wdata_sr[DATA_WIDTH-2:0], 1'b0};
          end else begin
            cnt     <= cnt + 5'd1;
            DIN     <= addr_sr[ADDR_WIDTH-1];
            addr_sr <= {addr_sr[ADDR_WIDTH-2:0], 1'b0};
          end
        end
        S_DATA: begin
          // DOUT is captured on every data edge; writes simply discard it.
          rdata_sr <= rdata_next[DATA_WIDTH-2:0];
          if (cnt == DATA_LAST) begin
            state <= S_GAP;
            cnt   <= '0;
            DIN   <= 1'b0;
`ifdef REG_FILE_MASTER_VERIFY_EN
            if (is_wr) begin
              vpend <= 1'b1;
            end else begin
              rsp_valid <= 1'b1;
              rsp_rdata <= rdata_next;
              err_q     <= readback && (rdata_next != wdata_q);
            end
`else
            rsp_valid <= 1'b1;
            rsp_rdata <= is_wr ? '0 : rdata_next;
`endif
          end else begin
            cnt      <= cnt + 5'd1;
            DIN      <= is_wr & wdata_sr[DATA_WIDTH-1];
            wdata_sr <= {wdata_sr[DATA_WIDTH-2:0], 1'b0};
          end
        end
        S_GAP: begin
          if (cnt == gap_last) begin
            cnt   <= '0;
            state <= S_IDLE;
`ifdef REG_FILE_MASTER_VERIFY_EN
            if (vpend) begin
              vpend    <= 1'b0;
              readback <= 1'b1;
              is_wr    <= 1'b0;
              addr_sr  <= addr_q;
              RD_EN    <= 1'b1;
              state    <= S_STROBE;
            end
`endif
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
